// File: rtl/calib_upload_sched.sv
// Schedules completed calibration banks out of the ping-pong RAM and streams each
// one to the comm sender as a frame: 2-byte point count, then count*8 point bytes.
//
// state  | meaning
// IDLE   | nothing in flight; picks the oldest pending bank
// REQ    | o_tx_req held until ack, abandoned after ACK_TIMEOUT cycles
// HDR_HI | point count high byte on the stream
// HDR_LO | point count low byte (last byte when count is 0)
// RD     | one-cycle RAM read strobe for byte_idx
// RDWAIT | RD_LAT cycles until RAM data is captured
// SEND   | RAM byte held on the stream until accepted
// DONE   | frame_done pulse
module calib_upload_sched #(
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned MAX_POINTS  = 64,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_calib_make,
    input  logic        i_calib_pingpang,
    input  logic [15:0] i_calib_points,
    output logic        o_rd_en,
    output logic [10:0] o_rd_addr,
    input  logic [7:0]  i_rd_data,
    output logic        o_tx_req,
    input  logic        i_tx_ack,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_HDR_HI, S_HDR_LO, S_RD, S_RDWAIT, S_SEND, S_DONE
    } state_t;

    localparam logic [15:0] MAX_P = 16'(MAX_POINTS);

    state_t      state, state_nxt;
    logic [1:0]  pend;
    logic [15:0] slot_cnt [2];
    logic        first_bank;
    logic        cur_bank;
    logic [15:0] cur_cnt;
    logic [9:0]  byte_idx;
    logic [7:0]  data_q;
    logic [15:0] timer;

    logic        mk_bank, take, take_bank, streaming_mk;
    logic        mk_drop, mk_store, timeout_drop, last_byte;
    logic [1:0]  clr_vec, pend_kept, drop_inc;
    logic [8:0]  drop_sum;
    logic [15:0] clamped;

    assign mk_bank      = ~i_calib_pingpang;
    assign clamped      = (i_calib_points > MAX_P) ? MAX_P : i_calib_points;
    assign take         = (state == S_IDLE) && (|pend);
    assign take_bank    = (&pend) ? first_bank : pend[1];
    assign clr_vec      = take ? (2'b01 << take_bank) : 2'b00;
    assign pend_kept    = pend & ~clr_vec;
    assign streaming_mk = (state != S_IDLE) && (state != S_DONE) && (cur_bank == mk_bank);
    // A slot freed this very cycle can be refilled without counting a drop.
    assign mk_drop      = i_calib_make && (pend_kept[mk_bank] || streaming_mk);
    assign mk_store     = i_calib_make && !mk_drop;
    assign timeout_drop = (state == S_REQ) && !i_tx_ack && (timer == 16'd0);
    assign last_byte    = ({6'd0, byte_idx} == ((cur_cnt << 3) - 16'd1));
    assign drop_inc     = {1'b0, mk_drop} + {1'b0, timeout_drop};
    assign drop_sum     = {1'b0, o_drop_cnt} + {7'd0, drop_inc};

    assign o_busy    = (state != S_IDLE);
    assign o_rd_addr = (state == S_RD) ? {cur_bank, byte_idx} : 11'd0;

    always_comb begin
        state_nxt    = state;
        o_rd_en      = 1'b0;
        o_tx_req     = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_last    = 1'b0;
        o_tx_data    = 8'd0;
        o_frame_done = 1'b0;
        case (state)
            S_IDLE: if (|pend) state_nxt = S_REQ;
            S_REQ: begin
                o_tx_req = 1'b1;
                if (i_tx_ack)              state_nxt = S_HDR_HI;
                else if (timer == 16'd0)   state_nxt = S_IDLE;
            end
            S_HDR_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = cur_cnt[15:8];
                if (i_tx_ready) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = cur_cnt[7:0];
                o_tx_last  = (cur_cnt == 16'd0);
                if (i_tx_ready) state_nxt = (cur_cnt == 16'd0) ? S_DONE : S_RD;
            end
            S_RD: begin
                o_rd_en   = 1'b1;
                state_nxt = S_RDWAIT;
            end
            S_RDWAIT: if (timer == 16'd0) state_nxt = S_SEND;
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = data_q;
                o_tx_last  = last_byte;
                if (i_tx_ready) state_nxt = last_byte ? S_DONE : S_RD;
            end
            S_DONE: begin
                o_frame_done = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            pend        <= 2'b00;
            slot_cnt[0] <= 16'd0;
            slot_cnt[1] <= 16'd0;
            first_bank  <= 1'b0;
            cur_bank    <= 1'b0;
            cur_cnt     <= 16'd0;
            byte_idx    <= 10'd0;
            data_q      <= 8'd0;
            timer       <= 16'd0;
            o_drop_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            pend  <= pend_kept | (mk_store ? (2'b01 << mk_bank) : 2'b00);
            if (mk_store) begin
                slot_cnt[mk_bank] <= clamped;
                first_bank        <= pend_kept[~mk_bank] ? ~mk_bank : mk_bank;
            end
            if (take) begin
                cur_bank <= take_bank;
                cur_cnt  <= slot_cnt[take_bank];
                byte_idx <= 10'd0;
            end else if (state == S_SEND && i_tx_ready && !last_byte) begin
                byte_idx <= byte_idx + 10'd1;
            end else if (state == S_DONE) begin
                byte_idx <= 10'd0;
            end
            // One down-counter serves both the ack timeout and the read latency wait.
            if (take)
                timer <= ACK_TIMEOUT - 16'd1;
            else if (state == S_RD)
                timer <= 16'(RD_LAT - 1);
            else if ((state == S_REQ || state == S_RDWAIT) && timer != 16'd0)
                timer <= timer - 16'd1;
            if (state == S_RDWAIT && timer == 16'd0)
                data_q <= i_rd_data;
            o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_calib_upload_sched.sv
// Directed bench for calib_upload_sched: a frame-level model predicts every stream
// byte, read address, drop count and handshake, checked on every clock.
`timescale 1ns/1ps
module tb_calib_upload_sched;
    localparam int RD_LAT     = 2;
    localparam int MAX_POINTS = 64;
    localparam int TMO        = 40;

    logic        i_clk_50m = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_calib_make = 1'b0;
    logic        i_calib_pingpang = 1'b0;
    logic [15:0] i_calib_points = 16'd0;
    logic        o_rd_en;
    logic [10:0] o_rd_addr;
    logic [7:0]  i_rd_data;
    logic        o_tx_req;
    logic        i_tx_ack = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_tx_last;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_frame_done;
    logic [7:0]  o_drop_cnt;

    calib_upload_sched #(.RD_LAT(RD_LAT), .MAX_POINTS(MAX_POINTS), .ACK_TIMEOUT(16'(TMO))) dut (
        .i_clk_50m(i_clk_50m), .i_rst_n(i_rst_n), .i_calib_make(i_calib_make),
        .i_calib_pingpang(i_calib_pingpang), .i_calib_points(i_calib_points),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_tx_req(o_tx_req), .i_tx_ack(i_tx_ack), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_drop_cnt(o_drop_cnt));

    always #10 i_clk_50m = ~i_clk_50m;

    // RAM with RD_LAT pipeline; unread cycles return a marker never stored in mem.
    logic [7:0] mem [2048];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge i_clk_50m) begin
        rd_pipe[0] <= o_rd_en ? mem[o_rd_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_rd_data = rd_pipe[RD_LAT-1];

    int tests = 0, fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // ready: 0 always high, 1 random, 2 held low; ack pulses on the 3rd request cycle
    int  ready_mode = 0;
    bit  ack_en = 1'b1;
    int  req_cyc_drv = 0;
    initial forever begin
        @(posedge i_clk_50m); #1;
        i_tx_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (o_tx_req && ack_en) begin
            req_cyc_drv++;
            i_tx_ack = (req_cyc_drv == 3);
        end else begin
            req_cyc_drv = 0;
            i_tx_ack = 1'b0;
        end
    end

    // reference model
    bit         mq_bank [$];
    int         mq_cnt [$];
    logic [7:0] exp_q [$];
    bit   in_frame, acked, cur_b, expect_req_low, expect_fd, pv, pr, pl, tmo;
    logic [7:0] pd;
    int   cur_n, rd_ptr, req_cyc, m_drop, cyc;
    int   cur_len, cur_rds, cur_obs_bank, h0, h1, first_dc, last_dc;
    int   fr_done = 0;
    int   fr_len [$], fr_h0 [$], fr_h1 [$], fr_bank [$], fr_rds [$], fr_span [$];

    task automatic model_reset();
        mq_bank.delete(); mq_cnt.delete(); exp_q.delete();
        in_frame = 0; acked = 0; expect_req_low = 0; expect_fd = 0; pv = 0; m_drop = 0;
    endtask

    initial begin
        model_reset();
        cyc = 0;
        forever begin
            bit fd_due, dup, b;
            int n;
            @(negedge i_clk_50m);
            cyc++;
            if (!i_rst_n) begin
                model_reset();
                continue;
            end
            tmo = 0;
            fd_due = expect_fd;
            expect_fd = 0;
            chk("drop_cnt", o_drop_cnt, m_drop);
            if (pv && !pr) begin
                chk("valid_hold", o_tx_valid, 1);
                chk("data_hold", o_tx_data, pd);
                chk("last_hold", o_tx_last, pl);
            end
            if (expect_req_low) begin
                chk("req_drop", o_tx_req, 0);
                expect_req_low = 0;
            end
            if (o_tx_req && !in_frame) begin
                if (mq_bank.size() == 0) fail_now("req_start", "request with no bank queued");
                else begin
                    cur_b = mq_bank.pop_front();
                    cur_n = mq_cnt.pop_front();
                    in_frame = 1; acked = 0; req_cyc = 0; rd_ptr = 0;
                    cur_len = 0; cur_rds = 0; cur_obs_bank = -1;
                    exp_q.delete();
                    exp_q.push_back(8'(cur_n >> 8));
                    exp_q.push_back(8'(cur_n));
                    for (int i = 0; i < cur_n * 8; i++) exp_q.push_back(mem[{cur_b, 10'(i)}]);
                end
            end
            if (in_frame) chk("busy", o_busy, 1);
            else if (mq_bank.size() == 0) chk("busy_idle", o_busy, 0);
            chk("frame_done", o_frame_done, fd_due);
            if (fd_due) begin
                fr_len.push_back(cur_len); fr_h0.push_back(h0); fr_h1.push_back(h1);
                fr_bank.push_back(cur_obs_bank); fr_rds.push_back(cur_rds);
                fr_span.push_back(last_dc - first_dc);
                fr_done++;
                in_frame = 0;
            end else if (in_frame && !acked) begin
                chk("req_hold", o_tx_req, 1);
                chk("valid_in_req", o_tx_valid, 0);
                chk("rd_in_req", o_rd_en, 0);
                if (i_tx_ack) begin
                    acked = 1;
                    expect_req_low = 1;
                end else begin
                    req_cyc++;
                    if (req_cyc == TMO) tmo = 1;
                end
            end else if (in_frame && acked) begin
                chk("req_after_ack", o_tx_req, 0);
                if (o_rd_en) begin
                    chk("rd_addr", o_rd_addr, {cur_b, 10'(rd_ptr)});
                    chk("rd_in_range", (rd_ptr < cur_n * 8) ? 1 : 0, 1);
                    if (cur_obs_bank < 0) cur_obs_bank = int'(o_rd_addr[10]);
                    rd_ptr++;
                    cur_rds++;
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_q.size() == 0) fail_now("extra_byte", "byte accepted past frame end");
                    else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        chk("tx_data", o_tx_data, e);
                        chk("tx_last", o_tx_last, (exp_q.size() == 0) ? 1 : 0);
                        if (cur_len == 0) h0 = int'(o_tx_data);
                        if (cur_len == 1) h1 = int'(o_tx_data);
                        if (cur_len == 2) first_dc = cyc;
                        if (exp_q.size() == 0) begin
                            last_dc = cyc;
                            expect_fd = 1;
                        end
                        cur_len++;
                    end
                end
            end else begin
                chk("valid_idle", o_tx_valid, 0);
                chk("rd_en_idle", o_rd_en, 0);
            end
            if (i_calib_make) begin
                b = !i_calib_pingpang;
                n = (int'(i_calib_points) > MAX_POINTS) ? MAX_POINTS : int'(i_calib_points);
                dup = in_frame && (cur_b == b);
                foreach (mq_bank[k]) if (mq_bank[k] == b) dup = 1;
                if (dup) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else begin
                    mq_bank.push_back(b);
                    mq_cnt.push_back(n);
                end
            end
            if (tmo) begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                in_frame = 0;
                expect_req_low = 1;
            end
            pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data; pl = o_tx_last;
        end
    end

    task automatic do_make(input bit pp, input int pts);
        @(posedge i_clk_50m); #1;
        i_calib_make = 1'b1;
        i_calib_pingpang = pp;
        i_calib_points = 16'(pts);
        @(posedge i_clk_50m); #1;
        i_calib_make = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (fr_done < target && k < budget) begin
            @(negedge i_clk_50m); #1;
            k++;
        end
        chk("frames_done", fr_done, target);
    endtask

    task automatic check_frame(input string tag, input int k, input int len,
                               input int hi, input int lo, input int bank, input int rds);
        if (k >= fr_len.size()) begin
            fail_now(tag, "frame not logged");
            return;
        end
        chk({tag, "_len"}, fr_len[k], len);
        chk({tag, "_hdr_hi"}, fr_h0[k], hi);
        chk({tag, "_hdr_lo"}, fr_h1[k], lo);
        chk({tag, "_bank"}, fr_bank[k], bank);
        chk({tag, "_reads"}, fr_rds[k], rds);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 2048; i++) begin
            logic [7:0] v;
            v = 8'(i * 37 + (i >> 5));
            mem[i] = (v == 8'hEE) ? 8'h11 : v;
        end
        repeat (3) @(posedge i_clk_50m);
        #1;
        chk("rst_valid", o_tx_valid, 0);
        chk("rst_req", o_tx_req, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop_cnt, 0);
        i_rst_n = 1'b1;

        // full bank 0, ready held high
        do_make(1'b1, 64);
        wait_frames(1, 4000);
        check_frame("f64", 0, 514, 8'h00, 8'h40, 0, 512);
        if (fr_span.size() > 0) chk("throughput_span", fr_span[0], 511 * (RD_LAT + 2));
        chk("f64_drop", o_drop_cnt, 0);

        // clamped count, bank 1
        do_make(1'b0, 100);
        wait_frames(2, 4000);
        check_frame("f100", 1, 514, 8'h00, 8'h40, 1, 512);

        // empty bank: header only, no reads
        do_make(1'b1, 0);
        wait_frames(3, 200);
        check_frame("f0", 2, 2, 8'h00, 8'h00, -1, 0);

        // random backpressure
        ready_mode = 1;
        do_make(1'b0, 64);
        wait_frames(4, 8000);
        check_frame("fbp", 3, 514, 8'h00, 8'h40, 1, 512);

        // ordering plus a collision on the bank being streamed
        do_make(1'b1, 8);
        do_make(1'b0, 4);
        k = 0;
        while (!o_rd_en && k < 200) begin @(negedge i_clk_50m); #1; k++; end
        do_make(1'b1, 2);
        wait_frames(6, 2000);
        check_frame("ord0", 4, 66, 8'h00, 8'h08, 0, 64);
        check_frame("ord1", 5, 34, 8'h00, 8'h04, 1, 32);
        chk("collision_drop", o_drop_cnt, 1);
        ready_mode = 0;

        // ack timeout on bank 0, bank 1 served afterwards
        ack_en = 1'b0;
        do_make(1'b1, 3);
        do_make(1'b0, 2);
        k = 0;
        while (o_drop_cnt != 8'd2 && k < 200) begin @(negedge i_clk_50m); #1; k++; end
        chk("timeout_drop", o_drop_cnt, 2);
        ack_en = 1'b1;
        wait_frames(7, 500);
        check_frame("after_tmo", 6, 18, 8'h00, 8'h02, 1, 16);

        // reset while a data byte is stalled in SEND
        do_make(1'b1, 64);
        k = 0;
        while (k < 400) begin
            @(negedge i_clk_50m); #1;
            if (o_rd_en && o_rd_addr[9:0] == 10'd5) break;
            k++;
        end
        ready_mode = 2;
        k = 0;
        while (!o_tx_valid && k < 20) begin @(negedge i_clk_50m); #1; k++; end
        chk("stall_valid", o_tx_valid, 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_tx_valid, 0);
        chk("mid_rst_last", o_tx_last, 0);
        chk("mid_rst_data", o_tx_data, 0);
        chk("mid_rst_req", o_tx_req, 0);
        chk("mid_rst_rd", o_rd_en, 0);
        chk("mid_rst_addr", o_rd_addr, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_frame_done, 0);
        chk("mid_rst_drop", o_drop_cnt, 0);
        repeat (2) @(posedge i_clk_50m);
        #1 i_rst_n = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge i_clk_50m);
        chk("post_rst_busy", o_busy, 0);
        do_make(1'b0, 5);
        wait_frames(8, 500);
        check_frame("post_rst", 7, 42, 8'h00, 8'h05, 1, 40);
        chk("post_rst_drop", o_drop_cnt, 0);

        repeat (5) @(posedge i_clk_50m);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
